// File: rtl/fetch_branch_seq_if.sv
// Memory read port of the fetch sequencer. mem_req is held with a stable mem_addr
// until a one-cycle mem_rdy pulse returns mem_rdata.
interface fetch_branch_seq_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rdy;

  modport master (output mem_req, output mem_addr, input mem_rdata, input mem_rdy);
  modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_rdy);
endinterface

// File: rtl/fetch_branch_seq.sv
// SLC-3 fetch and control-flow sequencer: fetches into IR, resolves BR/JMP/JSR/JSRR
// locally and hands every other opcode to the execute FSM.
module fetch_branch_seq #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Run,
  fetch_branch_seq_if.master         mem,
  output logic [15:0]                IR,
  output logic [15:0]                PC,
  output logic                       Load_BEN,
  input  logic                       BEN,
  input  logic [15:0]                base_r,
  output logic                       r7_we,
  output logic [15:0]                r7_data,
  output logic                       exec_start,
  input  logic                       exec_done,
  output logic [2:0]                 state_dbg
);

  typedef enum logic [2:0] {
    S_HALT      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_BR_EVAL   = 3'd3,
    S_JMP       = 3'd4,
    S_JSR       = 3'd5,
    S_EXEC      = 3'd6,
    S_EXEC_WAIT = 3'd7
  } state_t;

  state_t      state, state_nx;
  logic [15:0] pc_q, pc_nx;
  logic [15:0] ir_q, ir_nx;
  logic        mem_req_c;
  state_t      done_nx;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_HALT;
      pc_q  <= PC_RESET;
      ir_q  <= 16'h0000;
    end else begin
      state <= state_nx;
      pc_q  <= pc_nx;
      ir_q  <= ir_nx;
    end
  end

  // Run is only consulted when an instruction retires, so in-flight work always finishes.
  assign done_nx = Run ? S_FETCH : S_HALT;

  always_comb begin
    state_nx   = state;
    pc_nx      = pc_q;
    ir_nx      = ir_q;
    mem_req_c  = 1'b0;
    Load_BEN   = 1'b0;
    r7_we      = 1'b0;
    r7_data    = pc_q;
    exec_start = 1'b0;
    case (state)
      S_HALT: begin
        if (Run) state_nx = S_FETCH;
      end
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem.mem_rdy) begin
          ir_nx    = mem.mem_rdata;
          pc_nx    = pc_q + 16'd1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        Load_BEN = 1'b1;
        case (ir_q[15:12])
          4'b0000: state_nx = S_BR_EVAL;
          4'b1100: state_nx = S_JMP;
          4'b0100: state_nx = S_JSR;
          default: state_nx = S_EXEC;
        endcase
      end
      S_BR_EVAL: begin
        if (BEN) pc_nx = pc_q + {{7{ir_q[8]}}, ir_q[8:0]};
        state_nx = done_nx;
      end
      S_JMP: begin
        pc_nx    = base_r;
        state_nx = done_nx;
      end
      S_JSR: begin
        // Return address is the already-incremented PC; base_r is read this cycle, so JSRR R7 uses the old R7.
        r7_we = 1'b1;
        if (ir_q[11]) pc_nx = pc_q + {{5{ir_q[10]}}, ir_q[10:0]};
        else          pc_nx = base_r;
        state_nx = done_nx;
      end
      S_EXEC: begin
        exec_start = 1'b1;
        state_nx   = S_EXEC_WAIT;
      end
      S_EXEC_WAIT: begin
        if (exec_done) state_nx = done_nx;
      end
      default: state_nx = S_HALT;
    endcase
  end

  assign mem.mem_req  = mem_req_c;
  assign mem.mem_addr = pc_q;
  assign PC           = pc_q;
  assign IR           = ir_q;
  assign state_dbg    = state;

endmodule
